cassette_adc_slicer: RTL
========================

# cassette_adc_slicer

Parametrised cassette-input slicer between the `ltc2308` ADC sample stream and the machine's cassette data input. It computes a running average over a power-of-two window held in a circular buffer, slices each sample against that average with runtime-programmable hysteresis, and reports level edges, edge-to-edge periods and carrier presence. The period and carrier outputs support fast-load decoding. It replaces the fixed 512-tap shift-register averager with a RAM-backed, width-generic block.

## Interface
- `DW`, 12: ADC sample width.
- `LOG2_DEPTH`, 9: averaging window is 2^LOG2_DEPTH samples (1..12).
- `CNTW`, 16: period counter width.
- `CARRIER_TIMEOUT`, 50000: cycles without an edge before `carrier` drops; must be < 2^CNTW.

Ports:
- `clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high.
- `sample_in`  in  DW  unsigned ADC sample; stable when `sample_sync` toggles.
- `sample_sync`  in  1  toggles once per new sample (ADC `dout_sync` style).
- `hyst`  in  DW  unsigned hysteresis threshold, sampled at compare time.
- `invert`  in  1  0: sample below band gives `level_out`=1 (CoCo polarity); 1: inverted.
- `level_out`  out  1  sliced cassette bit.
- `avg_out`  out  DW  current window average.
- `edge_stb`  out  1  one-cycle pulse on each `level_out` change.
- `period`  out  CNTW  clk cycles between the last two edges, saturating.
- `period_valid`  out  1  `period` holds a real edge-to-edge measurement.
- `carrier`  out  1  an edge occurred within the last CARRIER_TIMEOUT cycles.
- `window_full`  out  1  the window holds 2^LOG2_DEPTH real samples.

## Operation
- Toggle detect: `sync_d` registers `sample_sync`. Where `sync_d != sample_sync`, stage A latches `sample_in`, reads buffer[`wptr`] and sets `pend`.
- Stage B (next cycle):
  - `total` (DW+LOG2_DEPTH bits) <= `total` − old + new.
  - old is forced to 0 while `fill_cnt` < 2^LOG2_DEPTH, so the RAM needs no reset.
  - Write new to buffer[`wptr`]. `wptr` wraps modulo 2^LOG2_DEPTH. `fill_cnt` increments and saturates at 2^LOG2_DEPTH.
- Stage C: `avg_out` <= `total` >> LOG2_DEPTH (the updated total). `window_full` <= (`fill_cnt` == 2^LOG2_DEPTH).
- Stage D compare uses signed arithmetic at DW+2 bits, with no wrap at the rails:
  - lo = avg − hyst. hi = avg + hyst.
  - sample < lo sets raw=1. sample > hi sets raw=0. Otherwise raw holds.
  - `level_out` = raw XOR `invert`.
  - No compare or edge occurs while `window_full`=0; `level_out` holds its reset value.
- Edge: when `level_out` changes, `edge_stb`=1 for exactly one cycle.
- Period counter `pcnt` increments every cycle and saturates at all-ones.
  - On an edge cycle: `period` <= `pcnt`, then `pcnt` <= 1.
  - `period_valid` is set on the second and later edges after reset.
- Carrier: set on each edge. Cleared in the cycle `pcnt` reaches CARRIER_TIMEOUT.
- `invert` change with no sample: `level_out` flips and `edge_stb` pulses. This counts as an edge.

## Timing
- Reset values:
  - `level_out`=0 (the raw bit resets to `invert`).
  - `avg_out`=0, `edge_stb`=0, `period`=0, `period_valid`=0, `carrier`=0, `window_full`=0.
  - `pcnt`=0, `total`=0, `wptr`=0, `fill_cnt`=0, `pend`=0.
  - `sync_d` <= `sample_sync`, so no spurious sample is taken.
- Latency:
  - Toggle detected at edge N.
  - `avg_out` updates at N+2.
  - `level_out` and `edge_stb` update at N+3.
  - `period` updates in the same cycle as `edge_stb`.
- Toggles must be spaced at least 4 cycles apart. Closer spacing is undefined and is not checked.
- Reset asserted mid-window or mid-pipeline: all state clears on that edge, and the window refills from empty.
- The DW=12, LOG2_DEPTH=9 total is 21 bits and never overflows.

## Test plan
- LOG2_DEPTH=3, hyst=100: feed 8 samples of 2048.
  - `window_full` rises after the 8th sample.
  - `avg_out`=2048, `level_out`=0, no `edge_stb` pulses.
- Continue from the full window; feed 1900.
  - At N+3: `level_out`=1 with a single `edge_stb`.
  - `avg_out`=2029, which is (7·2048+1900)/8 truncated.
  - Then feed 2200: `level_out`=0 with one `edge_stb`.
  - Then 2000 and 2100: no edges.
- Rail case: full window of 50, hyst=100, then sample 0.
  - No flip, because lo=−50 and there is no unsigned wrap.
  - Full window of 4040, sample 4095: no flip.
- Square wave between 1000 and 3000, with the level changing every 1000 clk cycles.
  - After settling, each `edge_stb` is accompanied by `period`=1000 and `period_valid`=1.
  - `carrier`=1 throughout.
- Silence, CARRIER_TIMEOUT=5000: after the last edge, `carrier` clears exactly 4999 cycles later.
  - `period` holds its last value.
  - `pcnt` saturates at 65535 with no wrap.
- Reset pulse after 5 of 8 samples:
  - All outputs return to their reset values.
  - `window_full` rises only after 8 further samples.
  - The first `avg_out` excludes the pre-reset data.

Source files
------------

// File: rtl/cassette_adc_slicer.sv
// cassette_adc_slicer: running-average cassette slicer with hysteresis,
// edge strobe, edge-to-edge period measurement and carrier detect.
module cassette_adc_slicer #(
  parameter int DW = 12,
  parameter int LOG2_DEPTH = 9,
  parameter int CNTW = 16,
  parameter int CARRIER_TIMEOUT = 50000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [DW-1:0]   sample_in,
  input  logic            sample_sync,
  input  logic [DW-1:0]   hyst,
  input  logic            invert,
  output logic            level_out,
  output logic [DW-1:0]   avg_out,
  output logic            edge_stb,
  output logic [CNTW-1:0] period,
  output logic            period_valid,
  output logic            carrier,
  output logic            window_full
);
  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int TW = DW + LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0] FULL = (LOG2_DEPTH+1)'(DEPTH);
  logic [DW-1:0] mem [DEPTH];
  logic sync_d, pend, pend_b, pend_c, toggle, full, raw, raw_nxt, lvl_nxt, edge_nxt, seen;
  logic [DW-1:0] s_a, old, old_eff;
  logic [LOG2_DEPTH-1:0] wptr;
  logic [LOG2_DEPTH:0] fill_cnt;
  logic [TW-1:0] total;
  logic [CNTW-1:0] pcnt, pcnt_inc;
  logic signed [DW+1:0] smp, lo, hi;
  assign toggle = sync_d != sample_sync;
  assign full = fill_cnt == FULL;
  // Until the window is full the slot being overwritten was never counted.
  assign old_eff = full ? old : '0;
  assign smp = $signed({2'b00, s_a});
  assign lo = $signed({2'b00, avg_out}) - $signed({2'b00, hyst});
  assign hi = $signed({2'b00, avg_out}) + $signed({2'b00, hyst});
  assign pcnt_inc = &pcnt ? pcnt : pcnt + CNTW'(1);
  always_comb begin
    raw_nxt = (pend_c && window_full) ? (smp < lo ? 1'b1 : smp > hi ? 1'b0 : raw) : raw;
    lvl_nxt = window_full ? raw_nxt ^ invert : level_out;
    edge_nxt = lvl_nxt != level_out;
  end
  always_ff @(posedge clk) begin
    if (toggle) old <= mem[wptr];
    if (pend) mem[wptr] <= s_a;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_d <= sample_sync;
      pend <= 1'b0;
      pend_b <= 1'b0;
      pend_c <= 1'b0;
      s_a <= '0;
      wptr <= '0;
      fill_cnt <= '0;
      total <= '0;
      avg_out <= '0;
      window_full <= 1'b0;
      raw <= invert;
      level_out <= 1'b0;
      edge_stb <= 1'b0;
      pcnt <= '0;
      period <= '0;
      period_valid <= 1'b0;
      seen <= 1'b0;
      carrier <= 1'b0;
    end else begin
      sync_d <= sample_sync;
      pend <= toggle;
      pend_b <= pend;
      pend_c <= pend_b;
      if (toggle) s_a <= sample_in;
      if (pend) begin
        total <= total - TW'(old_eff) + TW'(s_a);
        wptr <= wptr + LOG2_DEPTH'(1);
        if (!full) fill_cnt <= fill_cnt + (LOG2_DEPTH+1)'(1);
      end
      if (pend_b) begin
        avg_out <= DW'(total >> LOG2_DEPTH);
        window_full <= full;
      end
      raw <= raw_nxt;
      level_out <= lvl_nxt;
      edge_stb <= edge_nxt;
      pcnt <= edge_nxt ? CNTW'(1) : pcnt_inc;
      if (edge_nxt) begin
        period <= pcnt;
        period_valid <= seen;
        seen <= 1'b1;
        carrier <= 1'b1;
      end else if (pcnt_inc == CNTW'(CARRIER_TIMEOUT)) carrier <= 1'b0;
    end
  end
endmodule
